pe_tile_scheduler: RTL and testbench

Sequencer that drives the 8x8 PE array through a multi-tile job. It accepts one job descriptor (tile count, compute depth) and, for each tile, runs four steps in order: operand load, compute beats, pipeline drain and result writeback. It then signals completion. It sits between the NPU command front-end and the PE array's `pe_valid`/`pe_ready` handshake, and issues load and writeback requests to the on-chip buffer controllers.

---
 rtl/pe_tile_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_pe_tile_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_tile_scheduler.sv
// ---------------------------------------------------------------------------
// pe_tile_scheduler
//
// Sequences the 8x8 PE array through a multi-tile job. One job descriptor
// (tile count, compute depth) is accepted in IDLE. Each tile then runs four
// steps in order: operand load, compute beats, pipeline drain and result
// writeback. A one-cycle done pulse follows the last tile.
//
// Parameters:
//   TILE_W        width of tile count / tile index
//   K_W           width of the compute-depth field
//   DRAIN_CYCLES  idle cycles between the last beat and the writeback (1..15)
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   job_valid / job_ready         job descriptor handshake
//   job_num_tiles, job_k_depth    descriptor; sampled only at acceptance
//   abort                         synchronous cancel (ignored in IDLE)
//   ld_req / ld_ack / ld_tile_idx operand load request to the buffer controller
//   pe_valid / pe_ready           compute beat handshake with the PE array
//   wb_req / wb_ack / wb_tile_idx result writeback request
//   busy                          high in every state except IDLE
//   done                          one-cycle pulse at job completion
//
// Optional feature (macro PE_SCHED_PERF_EN):
//   perf_busy_cycles   cycles with busy=1 since the last job acceptance
//   perf_stall_cycles  COMPUTE cycles with pe_ready=0 since the last acceptance
//   Both saturate at 0xFFFFFFFF.
// ---------------------------------------------------------------------------
module pe_tile_scheduler #(
   parameter int TILE_W       = 8,
   parameter int K_W          = 8,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [TILE_W-1:0] job_num_tiles,
   input  logic [K_W-1:0]    job_k_depth,
   input  logic              abort,
   output logic              ld_req,
   input  logic              ld_ack,
   output logic [TILE_W-1:0] ld_tile_idx,
   output logic              pe_valid,
   input  logic              pe_ready,
   output logic              wb_req,
   input  logic              wb_ack,
   output logic [TILE_W-1:0] wb_tile_idx,
   output logic              busy,
   output logic              done
`ifdef PE_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_busy_cycles,
   output logic [31:0]       perf_stall_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_DRAIN,
      S_WB,
      S_FIN
   } state_t;

   localparam logic [3:0]        DRAIN_INIT = 4'(DRAIN_CYCLES);
   localparam logic [TILE_W-1:0] TILE_ONE   = {{(TILE_W-1){1'b0}}, 1'b1};
   localparam logic [K_W:0]      BEAT_ONE   = {{K_W{1'b0}}, 1'b1};

   state_t            state;
   state_t            next_state;
   logic              job_ready_q;
   logic [TILE_W-1:0] num_tiles;
   logic [K_W-1:0]    k_eff;
   logic [TILE_W-1:0] tile_idx;
   logic [K_W:0]      beat_cnt;
   logic [3:0]        drain_cnt;

   logic              accept;
   logic              abort_hit;
   logic              beat;
   logic              last_beat;
   logic              last_tile;
   logic [K_W:0]      beat_cnt_inc;
   logic [K_W-1:0]    k_depth_eff;

   // job_ready is a flop (not a state decode) so it reads 0 while reset is
   // asserted and rises on the first edge after release.
   assign accept       = (state == S_IDLE) && job_ready_q && job_valid;
   assign abort_hit    = abort && (state != S_IDLE);
   assign beat         = (state == S_COMPUTE) && pe_ready;
   assign beat_cnt_inc = beat_cnt + BEAT_ONE;
   assign last_beat    = beat && (beat_cnt_inc == {1'b0, k_eff});
   assign last_tile    = (tile_idx == (num_tiles - TILE_ONE));
   assign k_depth_eff  = (job_k_depth == '0) ? {{(K_W-1){1'b0}}, 1'b1} : job_k_depth;

   // -----------------------------------------------------------------------
   // State register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         job_ready_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values, independent of statement order.
         state       <= next_state;
         job_ready_q <= (next_state == S_IDLE);
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      // NOTE: default assigned first so no path leaves next_state unassigned,
      // which would otherwise infer a latch.
      next_state = state;
      case (state)
         S_IDLE:    if (accept)
                       next_state = (job_num_tiles == '0) ? S_FIN : S_LOAD;
         S_LOAD:    if (ld_ack)            next_state = S_COMPUTE;
         S_COMPUTE: if (last_beat)         next_state = S_DRAIN;
         S_DRAIN:   if (drain_cnt == 4'd1) next_state = S_WB;
         S_WB:      if (wb_ack)            next_state = last_tile ? S_FIN : S_LOAD;
         S_FIN:                            next_state = S_IDLE;
         default:                          next_state = S_IDLE;
      endcase
      // Abort overrides everything outside IDLE; in IDLE it has no effect.
      if (abort_hit) next_state = S_IDLE;
   end

   // -----------------------------------------------------------------------
   // Job descriptor and counters
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_tiles <= '0;
         k_eff     <= '0;
         tile_idx  <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else if (!abort_hit) begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  num_tiles <= job_num_tiles;
                  k_eff     <= k_depth_eff;
                  tile_idx  <= '0;
               end
            end
            S_LOAD: begin
               if (ld_ack) beat_cnt <= '0;
            end
            S_COMPUTE: begin
               if (beat) beat_cnt <= beat_cnt_inc;
               if (last_beat) drain_cnt <= DRAIN_INIT;
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt - 4'd1;
            end
            S_WB: begin
               if (wb_ack && !last_tile) tile_idx <= tile_idx + TILE_ONE;
            end
            default: ;
         endcase
      end
   end

   // -----------------------------------------------------------------------
   // Outputs, decoded from registered state only
   // -----------------------------------------------------------------------
   always_comb begin
      ld_req      = 1'b0;
      pe_valid    = 1'b0;
      wb_req      = 1'b0;
      done        = 1'b0;
      ld_tile_idx = '0;
      wb_tile_idx = '0;
      case (state)
         S_LOAD: begin
            ld_req      = 1'b1;
            ld_tile_idx = tile_idx;
         end
         S_COMPUTE: pe_valid = 1'b1;
         S_WB: begin
            wb_req      = 1'b1;
            wb_tile_idx = tile_idx;
         end
         S_FIN:     done = 1'b1;
         default: ;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign job_ready = job_ready_q;

`ifdef PE_SCHED_PERF_EN
   // -----------------------------------------------------------------------
   // Performance counters: cleared on acceptance, saturating
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else if (accept) begin
         perf_busy_cycles  <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (busy && (perf_busy_cycles != '1))
            perf_busy_cycles <= perf_busy_cycles + 32'd1;
         if ((state == S_COMPUTE) && !pe_ready && (perf_stall_cycles != '1))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_tile_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for pe_tile_scheduler (DRAIN_CYCLES = 4).
// Table-driven jobs with expected beat / busy / stall counts, a tile-index
// scoreboard for load and writeback requests, and hand-written sequences for
// reset, abort in IDLE and abort mid-COMPUTE.
// ---------------------------------------------------------------------------
module tb_pe_tile_scheduler;

   localparam int TILE_W = 8;
   localparam int K_W    = 8;
   localparam int DRAIN  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              job_valid;
   logic              job_ready;
   logic [TILE_W-1:0] job_num_tiles;
   logic [K_W-1:0]    job_k_depth;
   logic              abort;
   logic              ld_req;
   logic              ld_ack;
   logic [TILE_W-1:0] ld_tile_idx;
   logic              pe_valid;
   logic              pe_ready;
   logic              wb_req;
   logic              wb_ack;
   logic [TILE_W-1:0] wb_tile_idx;
   logic              busy;
   logic              done;
`ifdef PE_SCHED_PERF_EN
   logic [31:0]       perf_busy_cycles;
   logic [31:0]       perf_stall_cycles;
`endif

   pe_tile_scheduler #(
      .TILE_W       (TILE_W),
      .K_W          (K_W),
      .DRAIN_CYCLES (DRAIN)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_num_tiles (job_num_tiles),
      .job_k_depth   (job_k_depth),
      .abort         (abort),
      .ld_req        (ld_req),
      .ld_ack        (ld_ack),
      .ld_tile_idx   (ld_tile_idx),
      .pe_valid      (pe_valid),
      .pe_ready      (pe_ready),
      .wb_req        (wb_req),
      .wb_ack        (wb_ack),
      .wb_tile_idx   (wb_tile_idx),
      .busy          (busy),
      .done          (done)
`ifdef PE_SCHED_PERF_EN
      ,
      .perf_busy_cycles  (perf_busy_cycles),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard: tile indices expected on load / writeback requests.
   logic [TILE_W-1:0] ld_q[$];
   logic [TILE_W-1:0] wb_q[$];

   typedef struct {
      int nt;         // job_num_tiles
      int k;          // job_k_depth
      int ld_dly;     // cycles ld_req waits before ld_ack
      int wb_dly;     // cycles wb_req waits before wb_ack
      bit toggle;     // pe_ready 1,0,1,0,... per compute cycle
      int exp_beats;  // accepted beats over the whole job
      int exp_pv;     // cycles with pe_valid=1
      int exp_busy;   // cycles with busy=1 (includes FIN)
      int exp_stall;  // COMPUTE cycles with pe_ready=0
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge. Accepts one job, answers requests, returns at the
   // negedge one cycle after the done pulse.
   task automatic run_job(input vec_t v);
      int  beats   = 0;
      int  pv_c    = 0;
      int  busy_c  = 0;
      int  stall_c = 0;
      int  done_c  = 0;
      int  ld_wait = 0;
      int  wb_wait = 0;
      int  pv_idx  = 0;
      int  cyc     = 0;
      bit  fin     = 1'b0;

      check("job_ready_before_accept", job_ready, 1);
      job_valid     = 1'b1;
      job_num_tiles = TILE_W'(v.nt);
      job_k_depth   = K_W'(v.k);
      for (int i = 0; i < v.nt; i++) begin
         ld_q.push_back(TILE_W'(i));
         wb_q.push_back(TILE_W'(i));
      end
      @(negedge clk);
      job_valid     = 1'b0;
      job_num_tiles = TILE_W'($urandom);
      job_k_depth   = K_W'($urandom);
      check("accept_to_ld_req", ld_req, (v.nt != 0) ? 1 : 0);
      check("accept_to_done",   done,   (v.nt == 0) ? 1 : 0);

      while (!fin && cyc < 3000) begin
         if (busy) busy_c++;
         check("one_active_output",
               ((int'(ld_req) + int'(pe_valid) + int'(wb_req) + int'(done)) <= 1) ? 1 : 0, 1);

         if (ld_req) begin
            if (ld_q.size() == 0) check("ld_req_unexpected", 1, 0);
            else                  check("ld_tile_idx", ld_tile_idx, ld_q[0]);
            if (ld_wait == v.ld_dly) begin
               ld_ack  = 1'b1;
               ld_wait = 0;
               if (ld_q.size() != 0) void'(ld_q.pop_front());
            end else begin
               ld_ack = 1'b0;
               ld_wait++;
            end
         end else begin
            ld_ack = 1'b0;
         end

         if (wb_req) begin
            if (wb_q.size() == 0) check("wb_req_unexpected", 1, 0);
            else                  check("wb_tile_idx", wb_tile_idx, wb_q[0]);
            if (wb_wait == v.wb_dly) begin
               wb_ack  = 1'b1;
               wb_wait = 0;
               if (wb_q.size() != 0) void'(wb_q.pop_front());
            end else begin
               wb_ack = 1'b0;
               wb_wait++;
            end
         end else begin
            wb_ack = 1'b0;
         end

         if (pe_valid) begin
            pv_c++;
            pe_ready = v.toggle ? ((pv_idx % 2) == 0) : 1'b1;
            if (pe_ready) beats++;
            else          stall_c++;
            pv_idx++;
         end else begin
            pv_idx   = 0;
            pe_ready = 1'b1;
         end

         if (done) begin
            done_c++;
         end else if (done_c > 0) begin
            fin = 1'b1;
            check("job_ready_after_done", job_ready, 1);
         end

         cyc++;
         if (!fin) @(negedge clk);
      end

      if (!fin) check("job_timeout", 0, 1);
      check("beats",        beats,   v.exp_beats);
      check("pe_valid_cyc", pv_c,    v.exp_pv);
      check("busy_cycles",  busy_c,  v.exp_busy);
      check("stall_cycles", stall_c, v.exp_stall);
      check("done_pulses",  done_c,  1);
      check("ld_q_empty",   ld_q.size(), 0);
      check("wb_q_empty",   wb_q.size(), 0);
`ifdef PE_SCHED_PERF_EN
      check("perf_busy",  perf_busy_cycles,  v.exp_busy);
      check("perf_stall", perf_stall_cycles, v.exp_stall);
`endif
      ld_q.delete();
      wb_q.delete();
      ld_ack   = 1'b0;
      wb_ack   = 1'b0;
      pe_ready = 1'b1;
   endtask

   vec_t vecs[8];

   initial begin
      int          cyc;
      logic [TILE_W-1:0] last_ld;
      bit          seen_tile1;

      //         nt  k  ld wb tog beats pv  busy stall
      vecs[0] = '{2,   3, 0, 0, 0,   6,   6,  19, 0};
      vecs[1] = '{0,   5, 0, 0, 0,   0,   0,   1, 0};
      vecs[2] = '{1,   0, 0, 0, 0,   1,   1,   8, 0};
      vecs[3] = '{1,   4, 0, 0, 1,   4,   7,  14, 3};
      vecs[4] = '{2,   2, 5, 3, 0,   4,   4,  33, 0};
      vecs[5] = '{3,   1, 0, 0, 0,   3,   3,  22, 0};
      vecs[6] = '{1, 255, 0, 0, 0, 255, 255, 262, 0};
      vecs[7] = '{2,   3, 1, 1, 1,   6,  10,  27, 4};

      rst_n         = 1'b0;
      job_valid     = 1'b0;
      job_num_tiles = '0;
      job_k_depth   = '0;
      abort         = 1'b0;
      ld_ack        = 1'b0;
      wb_ack        = 1'b0;
      pe_ready      = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_job_ready", job_ready, 0);
      check("rst_busy",      busy,      0);
      check("rst_ld_req",    ld_req,    0);
      check("rst_pe_valid",  pe_valid,  0);
      check("rst_wb_req",    wb_req,    0);
      check("rst_done",      done,      0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_job_ready", job_ready, 1);
      check("post_rst_busy",      busy,      0);
`ifdef PE_SCHED_PERF_EN
      check("rst_perf_busy",  perf_busy_cycles,  0);
      check("rst_perf_stall", perf_stall_cycles, 0);
`endif

      // Table-driven jobs
      for (int i = 0; i < 8; i++) run_job(vecs[i]);

      // Abort in IDLE is ignored: the job is still accepted.
      job_valid     = 1'b1;
      abort         = 1'b1;
      job_num_tiles = TILE_W'(2);
      job_k_depth   = K_W'(2);
      @(negedge clk);
      job_valid = 1'b0;
      check("idle_abort_accepted_ld_req", ld_req, 1);
      check("idle_abort_accepted_busy",   busy,   1);
      // abort still high in LOAD: back to IDLE next edge
      @(negedge clk);
      abort = 1'b0;
      check("load_abort_busy",   busy,   0);
      check("load_abort_ld_req", ld_req, 0);
      check("load_abort_done",   done,   0);

      // Abort mid-COMPUTE of tile 1 of 3, zero-wait acks.
      job_valid     = 1'b1;
      job_num_tiles = TILE_W'(3);
      job_k_depth   = K_W'(4);
      @(negedge clk);
      job_valid  = 1'b0;
      cyc        = 0;
      last_ld    = '0;
      seen_tile1 = 1'b0;
      while (!(pe_valid && seen_tile1) && cyc < 200) begin
         check("abort_seq_no_done", done, 0);
         ld_ack = ld_req;
         wb_ack = wb_req;
         if (ld_req) begin
            last_ld = ld_tile_idx;
            if (ld_tile_idx == TILE_W'(1)) seen_tile1 = 1'b1;
         end
         cyc++;
         @(negedge clk);
      end
      check("abort_seq_reached_tile1", (pe_valid && seen_tile1) ? 1 : 0, 1);
      check("abort_seq_ld_idx", last_ld, 1);
      ld_ack = 1'b0;
      wb_ack = 1'b0;
      // one beat in tile 1, then abort on the following cycle
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy",      busy,      0);
      check("abort_pe_valid",  pe_valid,  0);
      check("abort_ld_req",    ld_req,    0);
      check("abort_wb_req",    wb_req,    0);
      check("abort_done",      done,      0);
      check("abort_job_ready", job_ready, 1);
      // New job right away must start at tile 0 (scoreboard checks index).
      run_job(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
